// File: rtl/trivium_pkg.sv
// Shared Trivium constants, FSM encoding and key/IV-to-state packing helpers.
package trivium_pkg;

    localparam int ROUND_W     = 32;
    localparam int STATE_W     = 288;
    localparam int KEY_W       = 80;
    localparam int INIT_ROUNDS = 1152;

    // Session FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Reverse the bit order inside every byte: byte bit 7 becomes the lowest state index.
    function automatic logic [KEY_W-1:0] byte_bitrev(input logic [KEY_W-1:0] v);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int j = 0; j < KEY_W / 8; j++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*j+i] = v[8*j+7-i];
            end
        end
        return r;
    endfunction

    // Initial state: s1..s80 = key, s94..s173 = IV, s286..s288 = 1, rest 0 (s(i) = S[i-1]).
    function automatic logic [STATE_W-1:0] pack_state(input logic [KEY_W-1:0] key,
                                                      input logic [KEY_W-1:0] iv);
        return {3'b111, 108'b0, 4'b0, byte_bitrev(iv), 13'b0, byte_bitrev(key)};
    endfunction

endpackage

// File: rtl/trivium_stream_engine_if.sv
// Host/stream bundle of the Trivium engine: key/IV control, data in, data out.
interface trivium_stream_engine_if #(
    parameter int UNROLL = 9,
    parameter int NUM_W  = 16
);
    localparam int W = 32 * UNROLL;

    logic             EN;
    logic [79:0]      Key;
    logic             Krdy;
    logic             Kvld;
    logic [79:0]      IV;
    logic             Drdy;
    logic [NUM_W-1:0] Num;
    logic             Mode;
    logic             Abort;
    logic [W-1:0]     Din;
    logic             Din_vld;
    logic             Din_rdy;
    logic [W-1:0]     Dout;
    logic             Dout_vld;
    logic             Dout_rdy;
    logic             BSY;
    logic             Done;

    modport slave (
        input  EN, Key, Krdy, IV, Drdy, Num, Mode, Abort, Din, Din_vld, Dout_rdy,
        output Kvld, Din_rdy, Dout, Dout_vld, BSY, Done
    );

    modport master (
        output EN, Key, Krdy, IV, Drdy, Num, Mode, Abort, Din, Din_vld, Dout_rdy,
        input  Kvld, Din_rdy, Dout, Dout_vld, BSY, Done
    );

endinterface

// File: rtl/trivium_round32.sv
// Thirty-two Trivium rounds in one combinational step. All taps lie at least 32
// positions behind each register's insertion point, so every round reads only
// original state bits and the 32 rounds evaluate in parallel.
module trivium_round32
    import trivium_pkg::*;
(
    input  logic [STATE_W-1:0] s,
    output logic [STATE_W-1:0] n,
    output logic [ROUND_W-1:0] z
);

    logic [ROUND_W-1:0] a1;
    logic [ROUND_W-1:0] a2;
    logic [ROUND_W-1:0] a3;

    // Round k produces keystream bit z[31-k] and the feedback bits entering each register
    always_comb begin
        logic t1, t2, t3;
        z  = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int k = 0; k < ROUND_W; k++) begin
            t1 = s[65-k]  ^ s[92-k];
            t2 = s[161-k] ^ s[176-k];
            t3 = s[242-k] ^ s[287-k];
            z[31-k]  = t1 ^ t2 ^ t3;
            a1[31-k] = t1 ^ (s[90-k]  & s[91-k])  ^ s[170-k];
            a2[31-k] = t2 ^ (s[174-k] & s[175-k]) ^ s[263-k];
            a3[31-k] = t3 ^ (s[285-k] & s[286-k]) ^ s[68-k];
        end
    end

    // Each register shifts up by 32; the newest feedback bit lands at the register base
    assign n = {s[255:177], a2, s[144:93], a1, s[60:0], a3};

endmodule

// File: rtl/trivium_stream_engine.sv
// Trivium stream engine: key register, IV (re)sync, W-bit keystream or Din^keystream
// beats on a valid/ready stream with backpressure, continuous mode and abort.
module trivium_stream_engine
    import trivium_pkg::*;
#(
    parameter int UNROLL = 9,
    parameter int NUM_W  = 16
) (
    input  logic CLK,
    input  logic RSTn,
    trivium_stream_engine_if.slave bus
);

    localparam int W           = ROUND_W * UNROLL;
    localparam int INIT_CYCLES = INIT_ROUNDS / W;
    localparam int CNT_W       = $clog2(INIT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [NUM_W-1:0] BC_ONE   = NUM_W'(1);

    logic [1:0]         state;
    logic [STATE_W-1:0] s_reg;
    logic [KEY_W-1:0]   kreg;
    logic               kvld;
    logic [NUM_W-1:0]   num_q;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_W-1:0]   bc;
    logic               done_q;

    logic [STATE_W-1:0] chain [UNROLL+1];
    logic [W-1:0]       ks;
    logic               busy;
    logic               dout_vld;
    logic               fire;
    logic               last_beat;

    assign chain[0] = s_reg;

    for (genvar r = 0; r < UNROLL; r++) begin : g_round
        trivium_round32 u_round (
            .s (chain[r]),
            .n (chain[r+1]),
            .z (ks[W-1-ROUND_W*r -: ROUND_W])
        );
    end

    // Outputs are a pure function of registered state and inputs, so EN=0 leaves them unchanged
    assign busy      = (state != ST_IDLE);
    assign dout_vld  = (state == ST_RUN) && (mode_q ? bus.Din_vld : 1'b1);
    assign fire      = bus.EN && dout_vld && bus.Dout_rdy;
    assign last_beat = (num_q != '0) && ((bc + BC_ONE) == num_q);

    assign bus.Dout_vld = dout_vld;
    assign bus.Dout     = dout_vld ? (mode_q ? (bus.Din ^ ks) : ks) : '0;
    assign bus.Din_rdy  = dout_vld && mode_q && bus.Dout_rdy;
    assign bus.Kvld     = kvld;
    assign bus.BSY      = busy;
    assign bus.Done     = done_q;

    // Key register: loads only between sessions and survives sessions and aborts
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            kreg <= '0;
            kvld <= 1'b0;
        end else if (bus.EN && bus.Krdy && !busy) begin
            kreg <= bus.Key;
            kvld <= 1'b1;
        end
    end

    // Session FSM: start samples the pre-update key, INIT warms up, RUN advances per fired beat
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state  <= ST_IDLE;
            s_reg  <= '0;
            num_q  <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
            bc     <= '0;
            done_q <= 1'b0;
        end else if (bus.EN) begin
            done_q <= 1'b0;
            if (bus.Abort) begin
                if (busy) begin
                    done_q <= 1'b1;
                end
                state <= ST_IDLE;
                s_reg <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.Drdy && kvld) begin
                            s_reg  <= pack_state(kreg, bus.IV);
                            num_q  <= bus.Num;
                            mode_q <= bus.Mode;
                            cnt    <= '0;
                            bc     <= '0;
                            state  <= ST_INIT;
                        end
                    end
                    ST_INIT: begin
                        s_reg <= chain[UNROLL];
                        cnt   <= cnt + CNT_ONE;
                        if (cnt == CNT_LAST) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (fire) begin
                            s_reg <= chain[UNROLL];
                            bc    <= bc + BC_ONE;
                            if (last_beat) begin
                                state  <= ST_IDLE;
                                s_reg  <= '0;
                                done_q <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        s_reg <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trivium_stream_engine.sv
// Self-checking bench for trivium_stream_engine against a bit-serial Trivium model.
module tb_trivium_stream_engine;

    localparam int UNROLL   = 9;
    localparam int NUM_W    = 16;
    localparam int W        = 32 * UNROLL;
    localparam int INIT_CYC = 1152 / W;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    trivium_stream_engine_if #(.UNROLL(UNROLL), .NUM_W(NUM_W)) bus ();

    trivium_stream_engine #(.UNROLL(UNROLL), .NUM_W(NUM_W)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [288:1] ms;
    logic [79:0]  cur_key;
    logic [W-1:0] ks_exp;

    typedef struct {
        logic [79:0]      key;
        logic [79:0]      iv;
        logic [NUM_W-1:0] num;
        logic             mode;
        int               stall;
        int               gap;
        bit               din_ks;
        bit               est;
        logic [63:0]      exp64;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] brev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[(i/8)*8 + 7 - (i%8)] = v[i];
        return r;
    endfunction

    // One textbook Trivium round on the 1-based state s1..s288
    task automatic m_round(output logic z);
        logic t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
        ms[1] = t3;
        for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
        ms[94] = t1;
        for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
        ms[178] = t2;
    endtask

    task automatic m_load(input logic [79:0] key, input logic [79:0] iv);
        logic z;
        ms = '0;
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 8; i++) begin
                ms[8*j+i+1]  = key[8*j+7-i];
                ms[94+8*j+i] = iv[8*j+7-i];
            end
        end
        ms[286] = 1'b1;
        ms[287] = 1'b1;
        ms[288] = 1'b1;
        for (int r = 0; r < 1152; r++) m_round(z);
    endtask

    task automatic m_beat(output logic [W-1:0] b);
        logic z;
        for (int k = 0; k < W; k++) begin
            m_round(z);
            b[W-1-k] = z;
        end
    endtask

    task automatic load_key(input logic [79:0] k);
        @(negedge CLK);
        bus.Key  = k;
        bus.Krdy = 1'b1;
        @(negedge CLK);
        bus.Krdy = 1'b0;
        #1;
        check("kvld_after_load", bus.Kvld, 1'b1);
        cur_key = k;
    endtask

    // One session: start, count INIT cycles, stream and compare beats, then check Done/BSY
    task automatic session(input logic [79:0] iv, input logic [NUM_W-1:0] num, input logic mode,
                           input int stall, input int gap, input bit din_ks, input int abort_at,
                           input int en_at, input bit swap_key, input logic [79:0] new_key,
                           input bit est, input logic [63:0] exp64);
        int fired, cyc, init_cnt, en_cnt;
        bit ended, rdy, dvld, abort, en, est_done;
        logic [W-1:0] din_v, exp_dout;
        logic exp_vld;
        @(negedge CLK);
        bus.IV = iv; bus.Num = num; bus.Mode = mode; bus.Drdy = 1'b1;
        if (swap_key) begin bus.Key = new_key; bus.Krdy = 1'b1; end
        m_load(cur_key, iv);
        m_beat(ks_exp);
        @(negedge CLK);
        bus.Drdy = 1'b0; bus.Krdy = 1'b0;
        if (swap_key) cur_key = new_key;
        bus.Din_vld = mode; bus.Din = ks_exp; bus.Dout_rdy = 1'b0;
        #1;
        check("start_bsy", bus.BSY, 1'b1);
        init_cnt = 0;
        while (bus.Dout_vld !== 1'b1 && init_cnt < 50) begin
            init_cnt++;
            @(negedge CLK); #1;
        end
        check("init_cycles", W'(init_cnt), W'(INIT_CYC));
        fired = 0; cyc = 0; ended = 0; en_cnt = 0; est_done = 0;
        while (!ended && cyc < 3000) begin
            cyc++;
            rdy   = ($urandom_range(99) >= stall);
            dvld  = mode ? ($urandom_range(99) >= gap) : 1'b1;
            abort = (abort_at != 0 && fired == abort_at);
            en    = !(en_at != 0 && fired == en_at && en_cnt < 3);
            if (!en) begin en_cnt++; rdy = 1'b1; dvld = 1'b1; end
            if (abort) begin rdy = 1'b1; dvld = 1'b1; end
            if (din_ks) din_v = ks_exp;
            else for (int k = 0; k < UNROLL; k++) din_v[32*k +: 32] = $urandom();
            bus.Dout_rdy = rdy; bus.Din_vld = dvld; bus.Din = din_v;
            bus.Abort = abort; bus.EN = en;
            #1;
            exp_vld  = mode ? dvld : 1'b1;
            exp_dout = exp_vld ? (mode ? (din_v ^ ks_exp) : ks_exp) : '0;
            check("dout_vld", bus.Dout_vld, exp_vld);
            check("dout", bus.Dout, exp_dout);
            check("din_rdy", bus.Din_rdy, mode & dvld & rdy);
            if (est && !est_done) begin
                est_done = 1;
                n_tests++;
                if (bus.Dout[W-1 -: 64] !== exp64 && brev64(bus.Dout[W-1 -: 64]) !== exp64) begin
                    n_fail++;
                    $display("FAIL estream_first8: got %h expected %h", bus.Dout[W-1 -: 64], exp64);
                end
            end
            if (en && exp_vld && rdy) begin
                fired++;
                m_beat(ks_exp);
            end
            if (abort || (num != 0 && fired == int'(num))) ended = 1;
            @(negedge CLK); #1;
        end
        bus.EN = 1'b1;
        if (!ended) begin
            n_tests++; n_fail++;
            $display("FAIL session_timeout: got %0d beats expected end", fired);
        end
        bus.Abort = 1'b0; bus.Dout_rdy = 1'b0; bus.Din_vld = 1'b0;
        #1;
        check("end_done", bus.Done, 1'b1);
        check("end_bsy", bus.BSY, 1'b0);
        check("end_vld", bus.Dout_vld, 1'b0);
        check("end_dout", bus.Dout, '0);
        @(negedge CLK); #1;
        check("done_pulse_width", bus.Done, 1'b0);
    endtask

    initial begin
        logic [79:0] ivr, k2;
        bus.EN = 1'b1; bus.Key = '0; bus.Krdy = 1'b0; bus.IV = '0; bus.Drdy = 1'b0;
        bus.Num = '0; bus.Mode = 1'b0; bus.Abort = 1'b0; bus.Din = '0;
        bus.Din_vld = 1'b0; bus.Dout_rdy = 1'b0;
        cur_key = '0;

        tbl[0] = '{key: 80'h0, iv: 80'h0, num: 2, mode: 0, stall: 0, gap: 0,
                   din_ks: 0, est: 1, exp64: 64'hFBE0BF265859051B};
        tbl[1] = '{key: 80'h0, iv: 80'h0, num: 2, mode: 0, stall: 50, gap: 0,
                   din_ks: 0, est: 1, exp64: 64'hFBE0BF265859051B};
        tbl[2] = '{key: 80'h0, iv: 80'h0, num: 4, mode: 1, stall: 20, gap: 40,
                   din_ks: 1, est: 0, exp64: 64'h0};
        tbl[3] = '{key: {$urandom(), $urandom(), 16'($urandom())}, iv: {$urandom(), $urandom(), 16'($urandom())},
                   num: 5, mode: 0, stall: 30, gap: 0, din_ks: 0, est: 0, exp64: 64'h0};
        tbl[4] = '{key: {$urandom(), $urandom(), 16'($urandom())}, iv: {$urandom(), $urandom(), 16'($urandom())},
                   num: 3, mode: 1, stall: 30, gap: 30, din_ks: 0, est: 0, exp64: 64'h0};

        // Reset values
        repeat (2) @(negedge CLK);
        #1;
        check("rst_kvld", bus.Kvld, 1'b0);
        check("rst_bsy", bus.BSY, 1'b0);
        check("rst_dout_vld", bus.Dout_vld, 1'b0);
        check("rst_din_rdy", bus.Din_rdy, 1'b0);
        check("rst_done", bus.Done, 1'b0);
        check("rst_dout", bus.Dout, '0);
        RSTn = 1'b1;

        // Start without a key is ignored
        @(negedge CLK); bus.Drdy = 1'b1;
        @(negedge CLK); bus.Drdy = 1'b0; #1;
        check("drdy_no_key_bsy", bus.BSY, 1'b0);

        load_key(80'h0);
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].key !== cur_key) load_key(tbl[i].key);
            session(tbl[i].iv, tbl[i].num, tbl[i].mode, tbl[i].stall, tbl[i].gap,
                    tbl[i].din_ks, 0, 0, 1'b0, 80'h0, tbl[i].est, tbl[i].exp64);
        end

        // Continuous mode aborted after 100 beats, then restart with the same IV
        ivr = {$urandom(), $urandom(), 16'($urandom())};
        session(ivr, '0, 1'b0, 0, 0, 1'b0, 100, 0, 1'b0, 80'h0, 1'b0, 64'h0);
        session(ivr, 16'd3, 1'b0, 10, 0, 1'b0, 0, 0, 1'b0, 80'h0, 1'b0, 64'h0);

        // Key and start in the same cycle: this session old key, next session new key
        k2 = {$urandom(), $urandom(), 16'($urandom())};
        session(ivr, 16'd2, 1'b0, 0, 0, 1'b0, 0, 0, 1'b1, k2, 1'b0, 64'h0);
        session(ivr, 16'd2, 1'b0, 0, 0, 1'b0, 0, 0, 1'b0, 80'h0, 1'b0, 64'h0);

        // EN held low mid-stream freezes the session
        session(ivr, 16'd4, 1'b0, 0, 0, 1'b0, 0, 2, 1'b0, 80'h0, 1'b0, 64'h0);

        // Abort while idle produces no Done
        @(negedge CLK); bus.Abort = 1'b1;
        @(negedge CLK); bus.Abort = 1'b0; #1;
        check("idle_abort_done", bus.Done, 1'b0);
        check("idle_abort_kvld", bus.Kvld, 1'b1);

        // Asynchronous reset in the middle of RUN
        @(negedge CLK); bus.IV = ivr; bus.Num = '0; bus.Mode = 1'b0; bus.Drdy = 1'b1;
        @(negedge CLK); bus.Drdy = 1'b0; bus.Dout_rdy = 1'b1;
        repeat (INIT_CYC + 3) @(negedge CLK);
        #1;
        check("pre_rst_vld", bus.Dout_vld, 1'b1);
        #2 RSTn = 1'b0;
        #1;
        check("arst_kvld", bus.Kvld, 1'b0);
        check("arst_bsy", bus.BSY, 1'b0);
        check("arst_vld", bus.Dout_vld, 1'b0);
        check("arst_dout", bus.Dout, '0);
        check("arst_done", bus.Done, 1'b0);
        check("arst_din_rdy", bus.Din_rdy, 1'b0);
        @(negedge CLK); RSTn = 1'b1; bus.Dout_rdy = 1'b0;
        bus.Drdy = 1'b1;
        @(negedge CLK); bus.Drdy = 1'b0; #1;
        check("post_rst_no_start", bus.BSY, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
